// File: rtl/uparc_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uparc_muldiv_pkg
// Purpose  : Shared constants, types and helpers for the multiply/divide unit.
//            Holds the operand width, md_op encodings, the FSM state type and
//            the datapath step-mode encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uparc_muldiv_pkg;

  localparam int UPARC_REG_WIDTH  = 32;
  localparam int UPARC_MDOP_WIDTH = 3;

  localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_MULT  = 3'd0;
  localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_MULTU = 3'd1;
  localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_DIV   = 3'd2;
  localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_DIVU  = 3'd3;
  localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_MTHI  = 3'd4;
  localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_MTLO  = 3'd5;
  localparam logic [UPARC_MDOP_WIDTH-1:0] UPARC_MDOP_NONE  = 3'd7;

  // Step-module mode select
  localparam logic STEP_MUL = 1'b0;
  localparam logic STEP_DIV = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Magnitude of v when treated as signed (sgn=1); v unchanged otherwise.
  // 0x80000000 maps to itself, which is its correct unsigned magnitude.
  function automatic logic [UPARC_REG_WIDTH-1:0] abs_if(
    input logic [UPARC_REG_WIDTH-1:0] v,
    input logic                       sgn
  );
    return (sgn && v[UPARC_REG_WIDTH-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage : uparc_muldiv_pkg
`default_nettype wire

// File: rtl/uparc_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : uparc_muldiv_step
// Purpose  : One radix-2 iteration of the multiply/divide datapath (pure
//            combinational).
//   mode     in   1   STEP_MUL: shift-add multiply, STEP_DIV: restoring divide
//   acc      in  64   multiply: {partial product, remaining multiplier}
//                     divide  : {partial remainder, remaining dividend/quotient}
//   operand  in  32   multiplicand or divisor magnitude
//   acc_next out 64   accumulator after this step (bit 0 clear in divide mode)
//   q_bit    out  1   quotient bit produced by a divide step (0 for multiply)
// Revision : 1.0 - initial release
// ============================================================================
module uparc_muldiv_step
  import uparc_muldiv_pkg::*;
(
  input  logic        mode,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next,
  output logic        q_bit
);

  logic [32:0] w_sum;
  logic [32:0] w_shifted;
  logic [31:0] w_trial;

  always_comb begin
    acc_next = '0;
    q_bit    = 1'b0;

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set; the 33rd bit carries into the shifted result.
    w_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);

    // Divide: bring the next dividend bit into the partial remainder and
    // trial-subtract. The compare is the 33-bit borrow test; when it passes
    // the true difference fits in 32 bits, so a 32-bit subtract suffices.
    w_shifted = {acc[63:32], acc[31]};
    w_trial   = w_shifted[31:0] - operand;

    if (mode == STEP_MUL) begin
      acc_next = {w_sum, acc[31:1]};
    end else begin
      q_bit    = (w_shifted >= {1'b0, operand});
      acc_next = {(q_bit ? w_trial : w_shifted[31:0]), acc[30:0], 1'b0};
    end
  end

endmodule : uparc_muldiv_step
`default_nettype wire

// File: rtl/uparc_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : uparc_muldiv
// Purpose  : Iterative multiply/divide unit with architectural HI/LO.
//            MULT/MULTU/DIV/DIVU take 32 RUN cycles plus one FIX cycle;
//            MTHI/MTLO write in a single cycle without busy/done.
//   clk    in   1   core clock
//   rst    in   1   synchronous active-high reset
//   start  in   1   launch operation (sampled only when idle)
//   md_op  in   3   operation code
//   a      in  32   rs operand
//   b      in  32   rt operand
//   cancel in   1   pipeline flush, aborts an in-flight operation
//   busy   out  1   operation in flight
//   done   out  1   one-cycle completion pulse; hi/lo valid this cycle
//   hi     out 32   HI register
//   lo     out 32   LO register
// Revision : 1.0 - initial release
// ============================================================================
module uparc_muldiv
  import uparc_muldiv_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [UPARC_MDOP_WIDTH-1:0] md_op,
  input  logic [UPARC_REG_WIDTH-1:0]  a,
  input  logic [UPARC_REG_WIDTH-1:0]  b,
  input  logic                        cancel,
  output logic                        busy,
  output logic                        done,
  output logic [UPARC_REG_WIDTH-1:0]  hi,
  output logic [UPARC_REG_WIDTH-1:0]  lo
);

  md_state_t   r_state;
  md_state_t   w_state_next;

  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic [4:0]  r_count;
  logic        r_is_div;
  logic        r_neg_q;     // quotient / product sign
  logic        r_neg_r;     // remainder sign (follows a)
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_idle_go;
  logic        w_launch;
  logic        w_signed;
  logic        w_div;
  logic [63:0] w_step_acc;
  logic        w_q_bit;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  // cancel suppresses any start seen while idle, including MTHI/MTLO
  assign w_idle_go = (r_state == MD_IDLE) && start && !cancel;
  assign w_signed  = (md_op == UPARC_MDOP_MULT) || (md_op == UPARC_MDOP_DIV);
  assign w_div     = (md_op == UPARC_MDOP_DIV)  || (md_op == UPARC_MDOP_DIVU);
  assign w_launch  = w_idle_go && (w_signed || w_div || (md_op == UPARC_MDOP_MULTU));

  uparc_muldiv_step u_step (
    .mode     (r_is_div),
    .acc      (r_acc),
    .operand  (r_opnd),
    .acc_next (w_step_acc),
    .q_bit    (w_q_bit)
  );

  // Sign correction applied in FIX on the magnitude result
  assign w_prod_fix = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quot_fix = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem_fix  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MD_IDLE: if (w_launch) w_state_next = MD_RUN;
      MD_RUN: begin
        if (cancel)              w_state_next = MD_IDLE;
        else if (r_count == 5'd0) w_state_next = MD_FIX;
      end
      MD_FIX:  w_state_next = MD_IDLE;
      default: w_state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= MD_IDLE;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (w_launch) begin
            // Both algorithms start with the first operand magnitude in the
            // low half and a cleared upper half.
            r_acc    <= {32'd0, abs_if(a, w_signed)};
            r_opnd   <= abs_if(b, w_signed);
            r_is_div <= w_div;
            r_neg_q  <= w_signed & (a[31] ^ b[31]);
            r_neg_r  <= w_signed & a[31];
            r_count  <= 5'd31;
          end
          if (w_idle_go && (md_op == UPARC_MDOP_MTHI)) r_hi <= a;
          if (w_idle_go && (md_op == UPARC_MDOP_MTLO)) r_lo <= a;
        end
        MD_RUN: begin
          r_acc   <= w_step_acc | {63'd0, w_q_bit};
          r_count <= r_count - 5'd1;
        end
        MD_FIX: begin
          if (!cancel) begin
            r_hi   <= r_is_div ? w_rem_fix  : w_prod_fix[63:32];
            r_lo   <= r_is_div ? w_quot_fix : w_prod_fix[31:0];
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != MD_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule : uparc_muldiv
`default_nettype wire

// File: tb/tb_uparc_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_uparc_muldiv
// Purpose  : Self-checking bench for uparc_muldiv. Expected {hi,lo} values are
//            queued when an operation is launched and compared when done
//            pulses; timing, cancel, reset and MTHI/MTLO are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uparc_muldiv;
  import uparc_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] scb[$];
  string       scb_tag[$];

  always #5 clk = ~clk;

  uparc_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .md_op  (md_op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the arithmetic definition
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sp;
    int     sx, sy, q, r;
    logic [63:0] res;
    sx = int'(x);
    sy = int'(y);
    res = '0;
    case (op)
      UPARC_MDOP_MULT: begin
        sp  = longint'(sx) * longint'(sy);
        res = sp;
      end
      UPARC_MDOP_MULTU: res = {32'd0, x} * {32'd0, y};
      UPARC_MDOP_DIVU: begin
        if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else            res = {x % y, x / y};
      end
      default: begin
        if (y == 32'd0)
          res = {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          res = {32'd0, 32'h8000_0000};
        else begin
          q   = sx / sy;
          r   = sx % sy;
          res = {r, q};
        end
      end
    endcase
    return res;
  endfunction

  // Scoreboard consumer
  always @(posedge clk) begin
    logic [63:0] e;
    string       t;
    #1;
    if (done === 1'b1) begin
      if (scb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = scb.pop_front();
        t = scb_tag.pop_front();
        check(t, {hi, lo}, e);
      end
    end
  end

  // Launch one arithmetic op, check busy length and done latency.
  // poke=1 asserts a competing start mid-run that must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input string tag, input bit poke);
    int idx;
    int busy_cnt;
    bit found;
    scb.push_back(exp);
    scb_tag.push_back(tag);
    start = 1'b1; md_op = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; md_op = UPARC_MDOP_NONE; a = $urandom; b = $urandom;
    idx = 1; busy_cnt = 0; found = 0;
    while (idx <= 60 && !found) begin
      if (done === 1'b1) begin
        found = 1;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (poke && idx == 5) begin
          start = 1'b1; md_op = UPARC_MDOP_MULT; a = 32'd2; b = 32'd3;
        end else begin
          start = 1'b0; md_op = UPARC_MDOP_NONE;
        end
        @(posedge clk); #1;
        idx++;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, found ? idx : 0, 64'd34);
    check({tag, "_busy_cycles"}, busy_cnt, 64'd33);
    check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; cancel = 1'b0; md_op = UPARC_MDOP_NONE; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic, back-to-back
    run_op(UPARC_MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max", 1'b1);
    run_op(UPARC_MDOP_MULT,  32'hFFFF_FFFD, 32'd5,         {32'hFFFF_FFFF, 32'hFFFF_FFF1}, "mult_neg3x5", 1'b0);
    run_op(UPARC_MDOP_MULT,  32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, "mult_min_sq", 1'b0);
    run_op(UPARC_MDOP_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg7_2", 1'b0);
    run_op(UPARC_MDOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, "div_min_m1", 1'b0);
    run_op(UPARC_MDOP_DIVU,  32'd7,         32'd0,         {32'h0000_0007, 32'hFFFF_FFFF}, "divu_by0", 1'b0);
    run_op(UPARC_MDOP_DIV,   32'hFFFF_FFF9, 32'd0,         {32'hFFFF_FFF9, 32'h0000_0001}, "div_neg_by0", 1'b0);
    run_op(UPARC_MDOP_DIV,   32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, "div_7_neg2", 1'b0);

    // Randomised ops against the model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb), "rand_op", 1'b0);
    end

    // MTHI / MTLO
    start = 1'b1; md_op = UPARC_MDOP_MTHI; a = 32'h0000_1234;
    @(posedge clk); #1;
    start = 1'b0; md_op = UPARC_MDOP_NONE;
    check("mthi_hi", {32'd0, hi}, 64'h1234);
    check("mthi_busy_done", {62'd0, busy, done}, 64'd0);
    start = 1'b1; md_op = UPARC_MDOP_MTLO; a = 32'h0000_5678;
    @(posedge clk); #1;
    start = 1'b0; md_op = UPARC_MDOP_NONE;
    check("mtlo_hilo", {hi, lo}, {32'h1234, 32'h5678});
    check("mtlo_busy_done", {62'd0, busy, done}, 64'd0);

    // Cancel mid-run; a start at T+5 must be ignored
    start = 1'b1; md_op = UPARC_MDOP_MULT; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; md_op = UPARC_MDOP_NONE;
    for (int i = 1; i < 10; i++) begin
      if (i == 5) begin
        start = 1'b1; md_op = UPARC_MDOP_MULTU; a = 32'd9; b = 32'd9;
      end else begin
        start = 1'b0; md_op = UPARC_MDOP_NONE;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("cancel_busy_before", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy_after", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("cancel_hilo", {hi, lo}, {32'h1234, 32'h5678});

    // cancel + start in idle: start dropped (arith and MTHI alike)
    start = 1'b1; cancel = 1'b1; md_op = UPARC_MDOP_MULTU; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    check("idle_cancel_start_busy", {63'd0, busy}, 64'd0);
    md_op = UPARC_MDOP_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_mthi", {hi, lo}, {32'h1234, 32'h5678});

    // Reserved op ignored
    start = 1'b1; md_op = 3'd6; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; md_op = UPARC_MDOP_NONE;
    check("reserved_op", {62'd0, busy, done}, 64'd0);
    @(posedge clk); #1;
    check("reserved_op_hilo", {hi, lo}, {32'h1234, 32'h5678});

    // Reset mid-operation
    start = 1'b1; md_op = UPARC_MDOP_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = UPARC_MDOP_NONE;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy_done", {62'd0, busy, done}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    run_op(UPARC_MDOP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_after_rst", 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", scb.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uparc_muldiv
`default_nettype wire

// File: doc/uparc_muldiv.md
Name: uparc_muldiv

Overview:
- Iterative multiply/divide unit for the execute stage. Handles the integer operations the combinational ALU does not: MULT, MULTU, DIV, DIVU, plus MTHI/MTLO writes.
- Owns the architectural HI/LO registers; the pipeline reads them directly for MFHI/MFLO.
- Accepts one operation per start pulse, stalls the pipeline via busy, and signals completion with a one-cycle done pulse.

Parameters:
- None. Operand width is fixed at `UPARC_REG_WIDTH (32).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  launch operation; sampled only when busy=0
- md_op  in  `UPARC_MDOP_WIDTH (3)  operation code
- a  in  32  rs operand
- b  in  32  rt operand
- cancel  in  1  pipeline flush; aborts an in-flight operation
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; hi/lo hold the new result this cycle
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: on the rst edge, hi=0, lo=0, busy=0, done=0, FSM=IDLE. rst overrides start and cancel, and aborts any operation in flight.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - latch operands; for signed ops, latch magnitudes and result-sign flags;
  - counter=31; go to RUN.
- IDLE, start=1, op MTHI/MTLO:
  - write hi or lo from a at the edge; visible next cycle;
  - stay in IDLE; no busy, no done.
- RUN: one radix-2 step per cycle, 32 cycles total; exit to FIX when counter=0.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring; 32-bit partial remainder, 33-bit trial subtract.
- FIX: apply sign correction (two's-complement negate), write hi/lo, assert done, return to IDLE.
- Timing, start sampled at edge T:
  - busy=1 in cycles T+1..T+33;
  - done=1 and new hi/lo visible in cycle T+34 only; busy=0 that cycle;
  - a new start is accepted in cycle T+34.
- start while busy=1: ignored. Operands are not re-latched.
- cancel while busy=1: FSM returns to IDLE at the next edge, busy=0 the cycle after cancel. hi/lo are unchanged and no done pulse occurs.
- cancel in IDLE: no effect. cancel and start in the same IDLE cycle: cancel wins, start ignored.
- Result placement:
  - multiply: hi = product[63:32], lo = product[31:0];
  - divide: lo = quotient, hi = remainder.
- Signed rules:
  - product sign = sign(a) XOR sign(b);
  - quotient sign = sign(a) XOR sign(b);
  - remainder takes the sign of a (truncating division).
- Divide by zero (no trap):
  - DIVU: lo=0xFFFFFFFF, hi=a;
  - DIV: lo=0xFFFFFFFF if a>=0, else 0x00000001; hi=a.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude algorithm; no special case.
- Reserved md_op with start=1: ignored, stays IDLE.

Decomposition:
- Add to uparc_cpu_const.vh:
  - `UPARC_MDOP_WIDTH;
  - `UPARC_MDOP_MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - `UPARC_MDOP_NONE=7.
- Keep the FSM, counter and HI/LO in uparc_muldiv.
- Put the per-cycle datapath step in one combinational sub-module, uparc_muldiv_step:
  - inputs: mode, accumulator/remainder, operand;
  - outputs: next accumulator/remainder and quotient bit.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at T → busy T+1..T+33; done at T+34 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 7/0 → lo=0xFFFFFFFF, hi=7. DIV 0xFFFFFFF9/0 → lo=0x00000001, hi=0xFFFFFFF9.
- Preload via MTHI 0x1234, MTLO 0x5678 (each visible next cycle, no done). Start MULT 3×4; cancel at T+10 → busy=0 at T+11, no done, hi=0x1234, lo=0x5678. A start at T+5 with other operands is ignored.
- Start DIVU 100/7; rst at T+20 → hi=lo=0, busy=0, done never pulses. A fresh DIVU 100/7 then completes in 34 cycles with lo=14, hi=2.
